// File: rtl/sim_trap_monitor.sv
// sim_trap_monitor
//
// Simulation-end responder. It watches the core's commit lanes for the trap
// instruction (ebreak, 0x00100073) and decides how simulation ended:
//   good trap (a0 == 0), bad trap (a0 != 0), or a hang caught by a watchdog
//   that counts consecutive cycles without any commit.
// It also keeps cycle and retired-instruction statistics for the bench.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high; forces IDLE and clears all outputs
//   commit_valid  in   [COMMIT_W]      lane i retires this cycle (lane 0 oldest)
//   commit_inst   in   [32*COMMIT_W]   instruction word per lane, lane i at [32i+31:32i]
//   commit_pc     in   [XLEN*COMMIT_W] PC per lane, same packing
//   commit_a0     in   [XLEN]          architectural a0 seen by the trapping lane
//   sim_done      out  sticky end-of-simulation flag
//   sim_status    out  0 running, 1 good trap, 2 bad trap, 3 timeout
//   trap_pc       out  PC of the trapping instruction (0 on timeout)
//   cycle_cnt     out  cycles spent in RUN
//   instr_cnt     out  instructions retired, including the trap
module sim_trap_monitor #(
  parameter int COMMIT_W = 2,
  parameter int XLEN     = 32,
  parameter int TIMEOUT  = 4096,
  parameter int CNT_W    = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COMMIT_W-1:0]      commit_valid,
  input  logic [32*COMMIT_W-1:0]   commit_inst,
  input  logic [XLEN*COMMIT_W-1:0] commit_pc,
  input  logic [XLEN-1:0]          commit_a0,
  output logic                     sim_done,
  output logic [1:0]               sim_status,
  output logic [XLEN-1:0]          trap_pc,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instr_cnt
);

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam int          WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]  ST_RUN   = 2'd0;
  localparam logic [1:0]  ST_GOOD  = 2'd1;
  localparam logic [1:0]  ST_BAD   = 2'd2;
  localparam logic [1:0]  ST_TMO   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [WD_W-1:0]   wd, wd_nxt;
  logic              done_nxt;
  logic [1:0]        status_nxt;
  logic [XLEN-1:0]   pc_nxt;
  logic [CNT_W-1:0]  cyc_nxt;
  logic [CNT_W-1:0]  instr_nxt;

  logic              any_commit;
  logic              trap_hit;
  logic [XLEN-1:0]   trap_lane_pc;
  logic [CNT_W-1:0]  retire_cnt;

  // Lane scan, oldest first. Lanes are counted up to and including the first
  // valid ebreak; anything younger than the trap never architecturally retires.
  always_comb begin
    trap_hit     = 1'b0;
    trap_lane_pc = '0;
    retire_cnt   = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_valid[i] && !trap_hit) begin
        retire_cnt = retire_cnt + CNT_W'(1);
        if (commit_inst[32*i +: 32] == EBREAK) begin
          trap_hit     = 1'b1;
          trap_lane_pc = commit_pc[XLEN*i +: XLEN];
        end
      end
    end
  end

  assign any_commit = |commit_valid;

  // Next-state and next-output logic. IDLE and RUN share the same datapath:
  // the first committing cycle already counts as a RUN cycle, so a trap there
  // finishes with cycle_cnt = 1. A commit always clears the watchdog, which is
  // why a trap can never collide with a timeout.
  always_comb begin
    state_nxt  = state;
    wd_nxt     = wd;
    done_nxt   = sim_done;
    status_nxt = sim_status;
    pc_nxt     = trap_pc;
    cyc_nxt    = cycle_cnt;
    instr_nxt  = instr_cnt;

    case (state)
      S_IDLE, S_RUN: begin
        if (any_commit) begin
          wd_nxt    = '0;
          state_nxt = S_RUN;
          cyc_nxt   = cycle_cnt + CNT_W'(1);
          instr_nxt = instr_cnt + retire_cnt;
          if (trap_hit) begin
            state_nxt  = S_DONE;
            done_nxt   = 1'b1;
            status_nxt = (commit_a0 == '0) ? ST_GOOD : ST_BAD;
            pc_nxt     = trap_lane_pc;
          end
        end else begin
          if (state == S_RUN) begin
            cyc_nxt = cycle_cnt + CNT_W'(1);
          end
          if (wd == WD_W'(TIMEOUT - 1)) begin
            state_nxt  = S_DONE;
            done_nxt   = 1'b1;
            status_nxt = ST_TMO;
            pc_nxt     = '0;
          end else begin
            wd_nxt = wd + WD_W'(1);
          end
        end
      end
      S_DONE: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt  = S_IDLE;
        status_nxt = ST_RUN;
      end
    endcase
  end

  // State and output registers; reset is synchronous and wins in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      wd         <= '0;
      sim_done   <= 1'b0;
      sim_status <= ST_RUN;
      trap_pc    <= '0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      wd         <= wd_nxt;
      sim_done   <= done_nxt;
      sim_status <= status_nxt;
      trap_pc    <= pc_nxt;
      cycle_cnt  <= cyc_nxt;
      instr_cnt  <= instr_nxt;
    end
  end

endmodule
